tdc_meas_sched: RTL

Measurement scheduler for the TDC counter bank. It arms the counters, waits for the synchronized snapshot-valid strobe from the clock-domain synchronizer, and stores each multi-counter snapshot in a small FIFO for host readout. It enforces a per-measurement timeout and a programmable run length. It sits between the synchronizer output and the host/readout logic, in the clocks[0] domain.

---
 rtl/tdc_meas_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tdc_meas_sched.sv
// Measurement scheduler: arms the TDC counters, waits for the snapshot strobe,
// and queues each multi-counter snapshot in a first-word fall-through FIFO.
module tdc_meas_sched #(
  parameter int CTR_NUMBER = 4,
  parameter int DATA_W     = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                         clocks,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [7:0]                   num_meas,
  input  logic [TIMEOUT_W-1:0]         timeout,
  input  logic [CTR_NUMBER*DATA_W-1:0] snap_data,
  input  logic                         snap_valid,
  output logic                         arm,
  output logic                         busy,
  input  logic                         rd_en,
  output logic [CTR_NUMBER*DATA_W-1:0] rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [7:0]                   meas_cnt,
  output logic                         timeout_err,
  output logic                         overflow
);
  localparam int SW = CTR_NUMBER * DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_STORE, S_GAP} state_t;

  state_t               r_state, w_state_nx;
  logic [7:0]           r_num, r_cnt, w_cnt_inc;
  logic [TIMEOUT_W-1:0] r_tmo, r_timer;
  logic                 r_gap, r_tmo_err, r_ovf;
  logic [SW-1:0]        r_hold, r_rd_data, w_rd_data_nx;
  logic [SW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr, r_rd_ptr, w_wr_ptr_nx, w_rd_ptr_nx;
  logic                 w_accept, w_tmo_hit, w_empty, w_full, w_wr, w_rd;

  assign w_accept    = (r_state == S_IDLE) && start && !abort;
  // snap_valid has priority over a coincident timeout
  assign w_tmo_hit   = (r_state == S_WAIT) && !snap_valid && (r_tmo != '0) &&
                       (r_timer == r_tmo - TIMEOUT_W'(1));
  assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // a full FIFO still accepts when the head is popped in the same cycle
  assign w_wr        = (r_state == S_STORE) && (!w_full || rd_en);
  assign w_rd        = rd_en && !w_empty;
  assign w_wr_ptr_nx = r_wr_ptr + (AW+1)'(w_wr);
  assign w_rd_ptr_nx = r_rd_ptr + (AW+1)'(w_rd);

  assign arm         = (r_state == S_ARM) || (r_state == S_WAIT);
  assign busy        = (r_state != S_IDLE);
  assign empty       = w_empty;
  assign full        = w_full;
  assign rd_data     = r_rd_data;
  assign meas_cnt    = r_cnt;
  assign timeout_err = r_tmo_err;
  assign overflow    = r_ovf;

  // state register
  always_ff @(posedge clocks or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;

  // next-state decode; abort overrides every transition
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_ARM;
      S_ARM:   w_state_nx = S_WAIT;
      S_WAIT:  if (snap_valid)     w_state_nx = S_STORE;
               else if (w_tmo_hit) w_state_nx = S_IDLE;
      S_STORE: w_state_nx = ((r_num != 8'd0) && (w_cnt_inc == r_num)) ? S_IDLE : S_GAP;
      S_GAP:   if (r_gap) w_state_nx = S_ARM;
      default: w_state_nx = S_IDLE;
    endcase
    if (abort) w_state_nx = S_IDLE;
  end

  // run parameters, timer, gap counter, counters and sticky flags
  always_ff @(posedge clocks or negedge rst)
    if (!rst) begin
      r_num     <= '0;
      r_tmo     <= '0;
      r_timer   <= '0;
      r_gap     <= 1'b0;
      r_cnt     <= '0;
      r_tmo_err <= 1'b0;
      r_ovf     <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_timer <= (r_state == S_WAIT) ? r_timer + TIMEOUT_W'(1) : '0;
      r_gap   <= (r_state == S_GAP) ? !r_gap : 1'b0;
      if (r_state == S_WAIT && snap_valid) r_hold <= snap_data;
      if (w_accept) begin
        r_num     <= num_meas;
        r_tmo     <= timeout;
        r_cnt     <= '0;
        r_tmo_err <= 1'b0;
        r_ovf     <= 1'b0;
      end
      // a STORE completes even when abort arrives in the same cycle
      if (r_state == S_STORE) begin
        r_cnt <= w_cnt_inc;
        if (!w_wr) r_ovf <= 1'b1;
      end
      if (w_tmo_hit && !abort) r_tmo_err <= 1'b1;
    end

  // FIFO storage, not reset: contents are invalidated by the pointers
  always_ff @(posedge clocks)
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= r_hold;

  // registered head: bypass a write into an empty slot, otherwise hold when empty
  always_comb begin
    w_rd_data_nx = r_rd_data;
    if (w_wr && (w_rd_ptr_nx == r_wr_ptr))  w_rd_data_nx = r_hold;
    else if (w_rd_ptr_nx != w_wr_ptr_nx)    w_rd_data_nx = r_mem[w_rd_ptr_nx[AW-1:0]];
  end

  // FIFO pointers and head register
  always_ff @(posedge clocks or negedge rst)
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nx;
      r_rd_ptr  <= w_rd_ptr_nx;
      r_rd_data <= w_rd_data_nx;
    end
endmodule
